// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a request-to-send,
// shifts an odd-parity frame out on device clock falling edges and checks the ack.
module ps2_host_tx #(
  parameter int CLK_INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES     = 750000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(CLK_INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, SHIFT, ACK, RELEASE} state_t;

  state_t        state;
  state_t        state_next;
  logic          clk_meta;
  logic          clk_sync;
  logic          clk_prev;
  logic          data_meta;
  logic          data_sync;
  logic [9:0]    frame;
  logic [3:0]    bit_cnt;
  logic          data_drive;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tout_cnt;
  logic          clk_fall;
  logic          active;
  logic          timeout_hit;
  logic          accept;
  logic          load_bit;

  assign clk_fall    = clk_prev & ~clk_sync;
  assign active      = (state == REQUEST) || (state == SHIFT) || (state == ACK) || (state == RELEASE);
  assign timeout_hit = active && (tout_cnt == TW'(TIMEOUT_CYCLES));

  // Bring the asynchronous pad levels into the clock domain; idle-high lines reset to 1
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  // State register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic, line drivers and the single-cycle done/error pulses
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    load_bit    = 1'b0;
    tx_done     = 1'b0;
    tx_error    = 1'b0;
    tx_busy     = (state != IDLE);
    ps2_clk_oe  = (state == INHIBIT);
    ps2_data_oe = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start) begin
          accept     = 1'b1;
          state_next = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt == IW'(CLK_INHIBIT_CYCLES - 1)) begin
          ps2_data_oe = 1'b1;
          state_next  = REQUEST;
        end
      end
      REQUEST: begin
        ps2_data_oe = 1'b1;
        if (timeout_hit) begin
          ps2_data_oe = 1'b0;
          tx_error    = 1'b1;
          state_next  = IDLE;
        end else if (clk_fall) begin
          load_bit   = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        ps2_data_oe = data_drive;
        if (timeout_hit) begin
          ps2_data_oe = 1'b0;
          tx_error    = 1'b1;
          state_next  = IDLE;
        end else if (clk_fall) begin
          load_bit = 1'b1;
          if (bit_cnt == 4'd9) state_next = ACK;
        end
      end
      ACK: begin
        if (timeout_hit) begin
          tx_error   = 1'b1;
          state_next = IDLE;
        end else if (clk_fall) begin
          if (!data_sync) begin
            state_next = RELEASE;
          end else begin
            tx_error   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      RELEASE: begin
        if (timeout_hit) begin
          tx_error   = 1'b1;
          state_next = IDLE;
        end else if (clk_sync && data_sync) begin
          tx_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame latch, bit shifter and the inhibit / saturating timeout counters
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      frame      <= '0;
      bit_cnt    <= '0;
      data_drive <= 1'b0;
      inh_cnt    <= '0;
      tout_cnt   <= '0;
    end else begin
      if (accept) begin
        frame      <= {1'b1, ~^tx_data, tx_data};
        bit_cnt    <= '0;
        data_drive <= 1'b0;
        inh_cnt    <= '0;
      end
      if (state == INHIBIT) begin
        inh_cnt  <= inh_cnt + 1'b1;
        tout_cnt <= '0;
      end else if (active && (tout_cnt != TW'(TIMEOUT_CYCLES))) begin
        tout_cnt <= tout_cnt + 1'b1;
      end
      if (load_bit) begin
        data_drive <= ~frame[bit_cnt];
        bit_cnt    <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_INHIBIT_CYCLES, default 5000: CLOCK_50 cycles that ps2 clock is held low before the start bit (100 us).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000: maximum cycles from clock release to ack completion (15 ms).
REQ-003 CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 tx_data  in  8  command byte to the keyboard, e.g. 8'hED set-LEDs.
REQ-006 tx_start  in  1  one-cycle request; tx_data is captured in the same cycle.
REQ-007 ps2_clk_in  in  1  raw ps2_clock pad level, asynchronous.
REQ-008 ps2_data_in  in  1  raw ps2_data pad level, asynchronous.
REQ-009 ps2_clk_oe  out  1  1 = pull ps2_clock low; 0 = release the line (high-Z).
REQ-010 ps2_data_oe  out  1  1 = pull ps2_data low; 0 = release the line (high-Z).
REQ-011 tx_busy  out  1  transfer in progress; the receiver ignores line activity while it is high.
REQ-012 tx_done  out  1  one-cycle pulse: device acked the byte.
REQ-013 tx_error  out  1  one-cycle pulse: NACK or timeout.

Function
REQ-014 ps2_clk_in and ps2_data_in SHALL pass through two-flop synchronizers; a falling edge is synchronized previous=1, current=0.
REQ-015 States SHALL be IDLE, INHIBIT, REQUEST, SHIFT, ACK, RELEASE.
REQ-016 tx_start SHALL be accepted only in IDLE, with tx_busy high from the next cycle; tx_start in any other state SHALL be ignored and SHALL NOT corrupt the latched byte.
REQ-017 On acceptance, the block SHALL latch a 10-bit frame {stop=1, parity=~^tx_data, tx_data} (LSB first) and clear a 4-bit edge counter.
REQ-018 INHIBIT: ps2_clk_oe=1 for exactly CLK_INHIBIT_CYCLES cycles; ps2_data_oe SHALL go to 1 (start bit) in the last INHIBIT cycle.
REQ-019 REQUEST: ps2_clk_oe=0, ps2_data_oe=1; the timeout counter SHALL clear on entry; the first falling edge SHALL move to SHIFT and drive frame bit 0.
REQ-020 SHIFT: each falling edge SHALL set ps2_data_oe = ~frame[n] and increment n; frame bits 0-7 are data, bit 8 is parity, and bit 9 is stop (line released).
REQ-021 ACK is entered on the falling edge after stop; on the next falling edge, sampled ps2_data=0 SHALL go to RELEASE, and sampled ps2_data=1 SHALL pulse tx_error and go to IDLE.
REQ-022 RELEASE SHALL wait until synchronized clock and data are both 1, then pulse tx_done for one cycle and go to IDLE.
REQ-023 If the timeout counter reaches TIMEOUT_CYCLES in REQUEST, SHIFT, ACK or RELEASE, the block SHALL release both lines in that cycle, pulse tx_error and go to IDLE; the timeout SHALL take priority over a simultaneous edge.
REQ-024 tx_done and tx_error SHALL never assert in the same cycle.
REQ-025 tx_busy SHALL equal (state != IDLE).
REQ-026 ps2_clk_oe SHALL be 1 only in INHIBIT.
REQ-027 The timeout counter SHALL saturate and never wrap; its width SHALL be ceil(log2(TIMEOUT_CYCLES+1)).

Reset
REQ-028 While resetn=0: state=IDLE; ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_error=0; counters, frame and synchronizers SHALL be set to 0, except synchronizers, which SHALL be set to 1.
REQ-029 Reset asserted mid-transfer SHALL release both lines asynchronously with no tx_done or tx_error pulse; the first tx_start after resetn=1 SHALL start a full new frame.

Verification
REQ-030 tx_data=8'hED with a device model clocking at 12.5 kHz and acking -> clock low 5000 cycles; data bits 1,0,1,1,0,1,1,1; parity 1; stop released; tx_done pulses once; tx_busy falls with it.
REQ-031 tx_data=8'h00 with device NACK (data high on the 11th edge) -> parity bit 1, tx_error one pulse, tx_done never asserted, state IDLE.
REQ-032 No device clocking after the clock release -> tx_error pulses exactly TIMEOUT_CYCLES cycles after REQUEST entry; both oe outputs are 0.
REQ-033 Second tx_start=1 with tx_data=8'hFF during SHIFT of 8'hED -> transmitted bits remain those of 8'hED; the transfer completes normally.
REQ-034 resetn pulsed low after the 4th data edge -> oe outputs go to 0 immediately; there is no done/error pulse; a later 8'hF4 transfer completes with tx_done.
